// File: rtl/matmul_apb_initiator.sv
// APB initiator for the matmul accelerator slave port.
// Takes single-beat commands from a valid/ready channel, runs one APB
// SETUP/ACCESS transfer per command and returns the result on a
// valid/ready response channel. An ACCESS phase that never sees pready
// is aborted after TIMEOUT_CYC cycles (0 = wait forever).
module matmul_apb_initiator #(
   parameter int BUS_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int MAX_DIM     = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
   input  logic [MAX_DIM-1:0]    cmd_strb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  busy_o,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [BUS_WIDTH-1:0]  pwdata,
   output logic [MAX_DIM-1:0]    pstrb,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [BUS_WIDTH-1:0]  prdata
);

   // The counter only has to reach TIMEOUT_CYC-1: the abort happens on the
   // ACCESS cycle where it already holds that value and pready is still low.
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYC > 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t                  state_q,   state_d;
   logic [CNT_W-1:0]        cnt_q,     cnt_d;
   logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
   logic                    pwrite_q,  pwrite_d;
   logic [BUS_WIDTH-1:0]    pwdata_q,  pwdata_d;
   logic [MAX_DIM-1:0]      pstrb_q,   pstrb_d;
   logic [BUS_WIDTH-1:0]    rdata_q,   rdata_d;
   logic                    err_q,     err_d;
   logic                    timeout_q, timeout_d;

   // Next-state and datapath update: every register holds unless its state acts on it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      timeout_d = timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               paddr_d  = cmd_addr_i;
               pwrite_d = cmd_write_i;
               pwdata_d = cmd_wdata_i;
               pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
               cnt_d    = '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               rdata_d   = pwrite_q ? '0 : prdata;
               err_d     = pslverr;
               timeout_d = 1'b0;
               state_d   = ST_RESP;
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               rdata_d   = '0;
               err_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns the bus to idle and drops any pending response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   // Bus controls decode straight from the state register; cmd_ready is held low while reset is asserted.
   always_comb begin
      psel          = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
      penable       = (state_q == ST_ACCESS);
      cmd_ready_o   = (state_q == ST_IDLE) && !rst;
      rsp_valid_o   = (state_q == ST_RESP);
      busy_o        = (state_q != ST_IDLE);
      pwrite        = pwrite_q;
      paddr         = paddr_q;
      pwdata        = pwdata_q;
      pstrb         = pstrb_q;
      rsp_rdata_o   = rdata_q;
      rsp_err_o     = err_q;
      rsp_timeout_o = timeout_q;
   end

endmodule

// File: tb/tb_matmul_apb_initiator.sv
// Self-checking bench for matmul_apb_initiator: a scripted APB responder
// plus a scoreboard queue of expected responses.
module tb_matmul_apb_initiator;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_write_i = 1'b0;
   logic [15:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic [3:0]  cmd_strb_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic        busy_o;
   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;
   logic [31:0] prdata = '0;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   rsp_t        exp_q[$];

   int          wait_cfg = 0;
   bit          hang_cfg = 1'b0;
   bit          slverr_cfg = 1'b0;
   logic [31:0] prdata_cfg = '0;
   int          acc_cnt = 0;

   matmul_apb_initiator #(
      .BUS_WIDTH  (32),
      .ADDR_WIDTH (16),
      .MAX_DIM    (4),
      .TIMEOUT_CYC(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_write_i  (cmd_write_i),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_wdata_i  (cmd_wdata_i),
      .cmd_strb_i   (cmd_strb_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o),
      .busy_o       (busy_o),
      .psel         (psel),
      .penable      (penable),
      .pwrite       (pwrite),
      .paddr        (paddr),
      .pwdata       (pwdata),
      .pstrb        (pstrb),
      .pready       (pready),
      .pslverr      (pslverr),
      .prdata       (prdata)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Cycle counter used to measure command spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // APB responder: raises pready after wait_cfg ACCESS cycles unless told to hang.
   always @(posedge clk) begin
      #1;
      if (psel && penable) begin
         pready  = !hang_cfg && (acc_cnt == wait_cfg);
         pslverr = slverr_cfg && pready;
         prdata  = prdata_cfg;
         acc_cnt = acc_cnt + 1;
      end else begin
         pready  = 1'b0;
         pslverr = 1'b0;
         acc_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command, waits for acceptance and records the expected response.
   task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input rsp_t e);
      cmd_write_i = wr;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      cmd_strb_i  = s;
      cmd_valid_i = 1'b1;
      for (int i = 0; i < 20 && !cmd_ready_o; i++) tick();
      vectors++;
      if (cmd_ready_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL accept: cmd_ready=%b, want 1", cmd_ready_o);
      end
      tick();
      cmd_valid_i = 1'b0;
      exp_q.push_back(e);
   endtask

   // Steps until a response is presented, giving up after 40 cycles.
   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid_o && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid_o, rsp_rdata_o,
           rsp_err_o, rsp_timeout_o, busy_o, cmd_ready_o} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: psel=%b pen=%b cmd_ready=%b busy=%b rsp_valid=%b paddr=%h, want all 0",
                  psel, penable, cmd_ready_o, busy_o, rsp_valid_o, paddr);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_release: cmd_ready=%b busy=%b, want 1 0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_write();
      rsp_t e;
      int n;
      wait_cfg = 0;
      issue(1'b1, 16'h0010, 32'hA5A5_0001, 4'hF, '{rdata: 32'h0, err: 1'b0, to: 1'b0});
      vectors++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready_o} !==
          {1'b1, 1'b0, 1'b1, 16'h0010, 32'hA5A5_0001, 4'hF, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL wr_setup: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h cmd_ready=%b, want 1 0 1 0010 a5a50001 f 0",
                  psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready_o);
      end
      tick();
      vectors++;
      if ({psel, penable, rsp_valid_o} !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL wr_access: psel/pen/rsp_valid=%b, want 110", {psel, penable, rsp_valid_o});
      end
      tick();
      wait_rsp(n);
      vectors++;
      if (n !== 0 || psel !== 1'b0 || penable !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_latency: extra cycles=%0d psel=%b pen=%b, want 0 0 0", n, psel, penable);
      end
      e = exp_q.pop_front();
      vectors++;
      if (!rsp_valid_o || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to) begin
         miscompares++;
         $display("[TB] FAIL wr_rsp: v=%b rdata=%h err=%b to=%b, want v=1 rdata=%h err=%b to=%b",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
      end
      tick();
      vectors++;
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || paddr !== 16'h0010) begin
         miscompares++;
         $display("[TB] FAIL wr_done: rsp_valid=%b cmd_ready=%b paddr=%h, want 0 1 0010",
                  rsp_valid_o, cmd_ready_o, paddr);
      end
   endtask

   task automatic test_read_wait();
      rsp_t e;
      int pen_cycles = 0;
      int bad_addr = 0;
      wait_cfg   = 3;
      prdata_cfg = 32'h0000_0003;
      issue(1'b0, 16'h0004, 32'h0, 4'h0, '{rdata: 32'h3, err: 1'b0, to: 1'b0});
      for (int i = 0; i < 40 && !rsp_valid_o; i++) begin
         tick();
         if (penable) begin
            pen_cycles++;
            if (paddr !== 16'h0004 || pwrite !== 1'b0) bad_addr++;
         end
      end
      vectors++;
      if (pen_cycles !== 4 || bad_addr !== 0) begin
         miscompares++;
         $display("[TB] FAIL rd_wait: penable cycles=%0d unstable=%0d, want 4 0", pen_cycles, bad_addr);
      end
      e = exp_q.pop_front();
      vectors++;
      if (!rsp_valid_o || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to) begin
         miscompares++;
         $display("[TB] FAIL rd_rsp: v=%b rdata=%h err=%b to=%b, want v=1 rdata=%h err=%b to=%b",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
      end
      tick();
      wait_cfg = 0;
   endtask

   task automatic test_slverr();
      rsp_t e;
      int n;
      slverr_cfg = 1'b1;
      prdata_cfg = 32'hDEAD_BEEF;
      issue(1'b0, 16'h0020, 32'h1234_5678, 4'hF, '{rdata: 32'hDEAD_BEEF, err: 1'b1, to: 1'b0});
      vectors++;
      if (pstrb !== 4'h0 || pwrite !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rd_pstrb: pstrb=%h pwrite=%b, want 0 0", pstrb, pwrite);
      end
      wait_rsp(n);
      e = exp_q.pop_front();
      vectors++;
      if (!rsp_valid_o || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to) begin
         miscompares++;
         $display("[TB] FAIL slverr_rsp: v=%b rdata=%h err=%b to=%b, want v=1 rdata=%h err=%b to=%b",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
      end
      tick();
      slverr_cfg = 1'b0;
   endtask

   task automatic test_timeout();
      rsp_t e;
      int pen_cycles = 0;
      hang_cfg   = 1'b1;
      prdata_cfg = 32'hFFFF_FFFF;
      issue(1'b0, 16'h0030, 32'h0, 4'h0, '{rdata: 32'h0, err: 1'b1, to: 1'b1});
      for (int i = 0; i < 40 && !rsp_valid_o; i++) begin
         tick();
         if (penable) pen_cycles++;
      end
      vectors++;
      if (pen_cycles !== 8 || psel !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_len: access cycles=%0d psel=%b, want 8 0", pen_cycles, psel);
      end
      e = exp_q.pop_front();
      vectors++;
      if (!rsp_valid_o || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to) begin
         miscompares++;
         $display("[TB] FAIL timeout_rsp: v=%b rdata=%h err=%b to=%b, want v=1 rdata=%h err=%b to=%b",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
      end
      tick();
      hang_cfg = 1'b0;
   endtask

   task automatic test_rsp_stall();
      rsp_t e;
      int n;
      rsp_ready_i = 1'b0;
      prdata_cfg  = 32'h0000_00C3;
      issue(1'b0, 16'h0008, 32'h0, 4'h0, '{rdata: 32'hC3, err: 1'b0, to: 1'b0});
      wait_rsp(n);
      e = exp_q.pop_front();
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b1;
      cmd_addr_i  = 16'h0040;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (!rsp_valid_o || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to ||
             cmd_ready_o !== 1'b0 || psel !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold%0d: v=%b rdata=%h err=%b to=%b cmd_ready=%b psel=%b, want 1 %h %b %b 0 0",
                     i, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, cmd_ready_o, psel, e.rdata, e.err, e.to);
         end
         tick();
      end
      cmd_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      tick();
      vectors++;
      if (rsp_valid_o !== 1'b0 || psel !== 1'b0 || cmd_ready_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stall_release: rsp_valid=%b psel=%b cmd_ready=%b, want 0 0 1",
                  rsp_valid_o, psel, cmd_ready_o);
      end
   endtask

   task automatic test_back_to_back();
      rsp_t e;
      int sent = 0;
      int last = 0;
      logic [15:0] addr_v;
      logic        wr_v;
      prdata_cfg = 32'h1234_5678;
      for (int c = 0; c < 40 && (sent < 3 || exp_q.size() > 0); c++) begin
         if (rsp_valid_o && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to) begin
               miscompares++;
               $display("[TB] FAIL b2b_rsp: rdata=%h err=%b to=%b, want %h %b %b",
                        rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
            end
         end
         if (cmd_ready_o && sent < 3) begin
            wr_v   = (sent != 1);
            addr_v = 16'h0100 + 16'(sent * 4);
            cmd_write_i = wr_v;
            cmd_addr_i  = addr_v;
            cmd_wdata_i = 32'hB000_0000 + 32'(sent);
            cmd_strb_i  = 4'h3;
            cmd_valid_i = 1'b1;
            exp_q.push_back('{rdata: wr_v ? 32'h0 : 32'h1234_5678, err: 1'b0, to: 1'b0});
            if (sent > 0) begin
               vectors++;
               if (cyc - last !== 4) begin
                  miscompares++;
                  $display("[TB] FAIL b2b_spacing: %0d cycles, want 4", cyc - last);
               end
            end
            last = cyc;
            sent++;
         end else if (cmd_ready_o) begin
            cmd_valid_i = 1'b0;
         end
         tick();
      end
      cmd_valid_i = 1'b0;
      vectors++;
      if (sent !== 3 || exp_q.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: sent=%0d pending=%0d, want 3 0", sent, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      rsp_t e;
      int n;
      hang_cfg = 1'b1;
      issue(1'b0, 16'h0050, 32'h0, 4'h0, '{rdata: 32'h0, err: 1'b0, to: 1'b0});
      tick();
      vectors++;
      if (penable !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rstmid_access: penable=%b, want 1", penable);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      void'(exp_q.pop_back());
      vectors++;
      if ({psel, penable, rsp_valid_o, busy_o, cmd_ready_o} !== 5'b00001) begin
         miscompares++;
         $display("[TB] FAIL rstmid_state: psel/pen/rsp_valid/busy/cmd_ready=%b, want 00001",
                  {psel, penable, rsp_valid_o, busy_o, cmd_ready_o});
      end
      hang_cfg   = 1'b0;
      prdata_cfg = 32'h0BAD_F00D;
      tick();
      issue(1'b0, 16'h0054, 32'h0, 4'h0, '{rdata: 32'h0BAD_F00D, err: 1'b0, to: 1'b0});
      wait_rsp(n);
      e = exp_q.pop_front();
      vectors++;
      if (!rsp_valid_o || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.to) begin
         miscompares++;
         $display("[TB] FAIL rstmid_rsp: v=%b rdata=%h err=%b to=%b, want v=1 rdata=%h err=%b to=%b",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
      end
      tick();
   endtask

   // Runs every scenario in order and prints the summary.
   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_rsp_stall();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
